// File: rtl/io_port_register.sv
// Buffered CPU output port: load/inc/clr command decode in front of a DEPTH-entry FIFO drained over valid/ready.
// Optional saturating command-error counter enabled by defining IOREG_ERRCNT_EN.
module io_port_register #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BUS_W = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         inc,
    input  logic                         clr,
    input  logic [BUS_W-1:0]             in_data,
    output logic [WIDTH-1:0]             out_data,
    output logic                         flag,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         dev_valid,
    input  logic                         dev_ready,
    output logic [WIDTH-1:0]             dev_data,
    output logic                         cmd_err,
    output logic [7:0]                   err_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_cmd_err;

    logic [PTR_W-1:0] w_head_nxt;
    logic [PTR_W-1:0] w_tail_nxt;
    logic [PTR_W-1:0] w_tail_last;
    logic [PTR_W-1:0] w_wr_addr;
    logic [CNT_W-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_wr_data;
    logic             w_wr_en;
    logic             w_err;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_conflict;
    logic             w_unused_bus;

    // Upper bus bits beyond WIDTH carry no port data.
    assign w_unused_bus = ^in_data;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_pop       = !w_empty && dev_ready;
    assign w_conflict  = (load && inc) || (load && clr) || (inc && clr);
    assign w_tail_last = r_tail - PTR_W'(1);

    // Command decode; the device pop always proceeds independently of CPU commands.
    always_comb begin
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count - CNT_W'(w_pop);
        w_wr_en     = 1'b0;
        w_wr_addr   = r_tail;
        w_wr_data   = in_data[WIDTH-1:0];
        w_err       = 1'b0;

        if (w_pop) begin
            w_head_nxt = r_head + PTR_W'(1);
        end

        if (w_conflict) begin
            w_err = 1'b1;
        end else if (load) begin
            if (!w_full || w_pop) begin
                w_wr_en     = 1'b1;
                w_tail_nxt  = r_tail + PTR_W'(1);
                w_count_nxt = r_count + CNT_W'(1) - CNT_W'(w_pop);
            end else begin
                w_err = 1'b1;
            end
        end else if (inc) begin
            if (w_empty) begin
                w_err = 1'b1;
            end else if (!((r_count == CNT_W'(1)) && w_pop)) begin
                // A single entry popped this cycle leaves with its pre-increment value.
                w_wr_en   = 1'b1;
                w_wr_addr = w_tail_last;
                w_wr_data = r_mem[w_tail_last] + WIDTH'(1);
            end
        end else if (clr) begin
            w_head_nxt  = '0;
            w_tail_nxt  = '0;
            w_count_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_cmd_err <= 1'b0;
        end else begin
            r_head    <= w_head_nxt;
            r_tail    <= w_tail_nxt;
            r_count   <= w_count_nxt;
            r_cmd_err <= w_err;
        end
    end

    // Storage is not reset; empty-gating on the outputs hides stale words.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

`ifdef IOREG_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

    assign count     = r_count;
    assign flag      = !w_full;
    assign dev_valid = !w_empty;
    assign dev_data  = w_empty ? '0 : r_mem[r_head];
    assign out_data  = w_empty ? '0 : r_mem[w_tail_last];
    assign cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_io_port_register.sv
// Self-checking bench for io_port_register: a model queue acts as scoreboard, words pushed on
// accepted loads and popped/compared against dev_data on each handshake.
module tb_io_port_register;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned BUS_W = 16;
    localparam int unsigned DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load = 1'b0;
    logic              inc = 1'b0;
    logic              clr = 1'b0;
    logic [BUS_W-1:0]  in_data = '0;
    logic [WIDTH-1:0]  out_data;
    logic              flag;
    logic [2:0]        count;
    logic              dev_valid;
    logic              dev_ready = 1'b0;
    logic [WIDTH-1:0]  dev_data;
    logic              cmd_err;
    logic [7:0]        err_count;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] mq[$];
    logic       exp_err = 1'b0;
    int         exp_ec = 0;

    io_port_register #(.WIDTH(WIDTH), .BUS_W(BUS_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .inc(inc), .clr(clr),
        .in_data(in_data), .out_data(out_data), .flag(flag), .count(count),
        .dev_valid(dev_valid), .dev_ready(dev_ready), .dev_data(dev_data),
        .cmd_err(cmd_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; scoreboard compares the head word on every modelled pop.
    task automatic step(input logic l, input logic i, input logic c,
                        input logic [15:0] d, input logic r);
        logic       pop;
        logic       full;
        int         ncmd;
        logic [7:0] t;
        @(negedge clk);
        load = l; inc = i; clr = c; in_data = d; dev_ready = r;
        #1;
        pop  = r && (mq.size() > 0);
        full = (mq.size() == DEPTH);
        ncmd = int'(l) + int'(i) + int'(c);
        if (pop) begin
            t = mq.pop_front();
            n_cmp++;
            if (dev_valid !== 1'b1 || dev_data !== t) begin
                n_fail++;
                $display("FAIL pop_word: got valid=%b data=%02h, need valid=1 data=%02h", dev_valid, dev_data, t);
            end
        end
        exp_err = 1'b0;
        if (ncmd >= 2) begin
            exp_err = 1'b1;
        end else if (l) begin
            if (!full || pop) mq.push_back(d[7:0]);
            else exp_err = 1'b1;
        end else if (i) begin
            if (mq.size() == 0 && !pop) exp_err = 1'b1;
            else if (mq.size() > 0) mq[mq.size()-1] = mq[mq.size()-1] + 8'd1;
        end else if (c) begin
            mq.delete();
        end
`ifdef IOREG_ERRCNT_EN
        if (exp_err && exp_ec < 255) exp_ec++;
`endif
        @(posedge clk);
        #1;
        load = 1'b0; inc = 1'b0; clr = 1'b0; dev_ready = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + 1; k++) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if (count !== 3'd0 || flag !== 1'b1 || dev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got count=%0d flag=%b valid=%b, need 0 1 0", count, flag, dev_valid);
        end
        n_cmp++;
        if (out_data !== 8'h00 || dev_data !== 8'h00 || cmd_err !== 1'b0 || err_count !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got out=%02h dev=%02h err=%b ec=%0d, need 0 0 0 0", out_data, dev_data, cmd_err, err_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete(); exp_ec = 0;
    endtask

    task automatic test_load();
        step(1'b1, 1'b0, 1'b0, 16'hAB12, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'hCD34, 1'b0);
        n_cmp++;
        if (count !== 3'd2 || dev_data !== 8'h12 || out_data !== 8'h34 || flag !== 1'b1) begin
            n_fail++;
            $display("FAIL load_two: got count=%0d dev=%02h out=%02h flag=%b, need 2 12 34 1", count, dev_data, out_data, flag);
        end
        drain();
        n_cmp++;
        if (count !== 3'd0 || dev_valid !== 1'b0 || mq.size() != 0) begin
            n_fail++;
            $display("FAIL load_drain: got count=%0d valid=%b, need 0 0", count, dev_valid);
        end
    endtask

    task automatic test_full();
        for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 1'b0, 16'(k), 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0005, 1'b0);
        n_cmp++;
        if (cmd_err !== 1'b1 || count !== 3'd4 || flag !== 1'b0 || out_data !== 8'h04) begin
            n_fail++;
            $display("FAIL full_drop: got err=%b count=%0d flag=%b out=%02h, need 1 4 0 04", cmd_err, count, flag, out_data);
        end
        step(1'b1, 1'b0, 1'b0, 16'h0005, 1'b1);
        n_cmp++;
        if (cmd_err !== 1'b0 || count !== 3'd4 || out_data !== 8'h05 || dev_data !== 8'h02) begin
            n_fail++;
            $display("FAIL full_push_pop: got err=%b count=%0d out=%02h dev=%02h, need 0 4 05 02", cmd_err, count, out_data, dev_data);
        end
        drain();
    endtask

    task automatic test_inc();
        step(1'b1, 1'b0, 1'b0, 16'h00FF, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        n_cmp++;
        if (out_data !== 8'h00 || dev_data !== 8'h00 || cmd_err !== 1'b0 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL inc_wrap: got out=%02h dev=%02h err=%b count=%0d, need 00 00 0 1", out_data, dev_data, cmd_err, count);
        end
        drain();
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        n_cmp++;
        if (cmd_err !== 1'b1 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL inc_empty: got err=%b count=%0d, need 1 0", cmd_err, count);
        end
        step(1'b1, 1'b0, 1'b0, 16'h0007, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        n_cmp++;
        if (cmd_err !== 1'b0 || count !== 3'd0 || dev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL inc_pop_single: got err=%b count=%0d valid=%b, need 0 0 0", cmd_err, count, dev_valid);
        end
    endtask

    task automatic test_conflict();
        int ec_before;
        step(1'b1, 1'b0, 1'b0, 16'h0021, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0022, 1'b0);
        ec_before = exp_ec;
        step(1'b1, 1'b0, 1'b1, 16'h0023, 1'b0);
        n_cmp++;
        if (cmd_err !== 1'b1 || count !== 3'd2 || out_data !== 8'h22 || dev_data !== 8'h21) begin
            n_fail++;
            $display("FAIL conflict: got err=%b count=%0d out=%02h dev=%02h, need 1 2 22 21", cmd_err, count, out_data, dev_data);
        end
`ifdef IOREG_ERRCNT_EN
        n_cmp++;
        if (err_count !== 8'(ec_before + 1)) begin
            n_fail++;
            $display("FAIL conflict_errcnt: got %0d, need %0d", err_count, ec_before + 1);
        end
`else
        n_cmp++;
        if (err_count !== 8'h00 || ec_before != 0) begin
            n_fail++;
            $display("FAIL conflict_errcnt: got %0d, need 0", err_count);
        end
`endif
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        n_cmp++;
        if (cmd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pulse_width: got %b, need 0", cmd_err);
        end
        drain();
    endtask

    task automatic test_clr_pop();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 16'(8'h40 + k), 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
        n_cmp++;
        if (count !== 3'd0 || dev_valid !== 1'b0 || flag !== 1'b1 || cmd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_pop: got count=%0d valid=%b flag=%b err=%b, need 0 0 1 0", count, dev_valid, flag, cmd_err);
        end
    endtask

    task automatic test_back_to_back();
        int         sel;
        logic       l, i, c, r;
        logic [7:0] exp_out;
        logic [7:0] exp_dev;
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            l = (sel <= 3) || (sel == 7);
            i = (sel == 4) || (sel == 5) || (sel == 7) || (sel == 9);
            c = (sel == 6) || (sel == 9);
            r = 1'($urandom_range(0, 1));
            step(l, i, c, 16'($urandom), r);
            exp_out = (mq.size() > 0) ? mq[mq.size()-1] : 8'h00;
            exp_dev = (mq.size() > 0) ? mq[0] : 8'h00;
            n_cmp++;
            if (count !== 3'(mq.size()) || flag !== (mq.size() != DEPTH) || dev_valid !== (mq.size() != 0)
                || cmd_err !== exp_err || out_data !== exp_out || dev_data !== exp_dev
                || err_count !== 8'(exp_ec)) begin
                n_fail++;
                $display("FAIL random_%0d: got count=%0d flag=%b valid=%b err=%b out=%02h dev=%02h ec=%0d, need %0d %b %b %b %02h %02h %0d",
                         n, count, flag, dev_valid, cmd_err, out_data, dev_data, err_count,
                         mq.size(), mq.size() != DEPTH, mq.size() != 0, exp_err, exp_out, exp_dev, exp_ec);
            end
        end
        drain();
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 1'b0, 16'h0051, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0052, 1'b0);
        n_cmp++;
        if (count !== 3'd2) begin
            n_fail++;
            $display("FAIL async_pre: got count=%0d, need 2", count);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (count !== 3'd0 || dev_valid !== 1'b0 || flag !== 1'b1 || dev_data !== 8'h00 || err_count !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: got count=%0d valid=%b flag=%b dev=%02h ec=%0d, need 0 0 1 00 0", count, dev_valid, flag, dev_data, err_count);
        end
        mq.delete(); exp_ec = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load();
        test_full();
        test_inc();
        test_conflict();
        test_clr_pop();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
